// File: rtl/conv_window_scheduler.sv
// Output-pixel sequencer for the 16-PE conv datapath: clear, stream one MAC window,
// drain PE results and write them to the OFM buffer as four packed 32-bit beats.
module conv_window_scheduler #(
  parameter int NUM_PE    = 16,
  parameter int ADDR_W    = 32,
  parameter int DRAIN_MAX = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          cfg_kernel_w,
  input  logic [11:0]         cfg_ifm_c,
  input  logic [11:0]         cfg_ofm_w,
  input  logic [11:0]         cfg_ofm_c,
  output logic                cal_start,
  output logic [NUM_PE-1:0]   PE_reset,
  output logic [NUM_PE-1:0]   PE_finish,
  input  logic [NUM_PE-1:0]   valid_in,
  input  logic [8*NUM_PE-1:0] ofm_data_in,
  output logic                ofm_wr_en,
  output logic [ADDR_W-1:0]   ofm_wr_addr,
  output logic [31:0]         ofm_wr_data,
  input  logic                ofm_wr_ready,
  output logic                busy,
  output logic                done,
  output logic                err_cfg,
  output logic                err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam int DCW = $clog2(DRAIN_MAX + 1);

  logic [2:0]          state_q, state_d;
  logic [19:0]         len_q, len_d;
  logic [19:0]         run_cnt_q, run_cnt_d;
  logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
  logic [11:0]         w_q, w_d;
  logic [11:0]         col_q, col_d;
  logic [11:0]         row_q, row_d;
  logic [ADDR_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   pix_q, pix_d;
  logic [7:0]          tiles_q, tiles_d;
  logic [7:0]          tile_q, tile_d;
  logic [1:0]          beat_q, beat_d;
  logic [8*NUM_PE-1:0] hold_q, hold_d;
  logic                err_cfg_q, err_cfg_d;
  logic                err_to_q, err_to_d;

  logic        cfg_ok;
  logic [7:0]  kk;
  logic [19:0] len_calc;
  logic        last_run;

  always_comb begin
    kk       = {4'd0, cfg_kernel_w} * {4'd0, cfg_kernel_w};
    len_calc = {12'd0, kk} * {10'd0, cfg_ifm_c[11:2]};
    cfg_ok   = (cfg_kernel_w != 4'd0) && (cfg_ifm_c != 12'd0) && (cfg_ifm_c[1:0] == 2'd0) &&
               (cfg_ofm_w != 12'd0) && (cfg_ofm_c != 12'd0) && (cfg_ofm_c[3:0] == 4'd0);
  end

  assign last_run = (run_cnt_q == len_q - 20'd1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    w_d         = w_q;
    col_d       = col_q;
    row_d       = row_q;
    step_d      = step_q;
    pix_d       = pix_q;
    tiles_d     = tiles_q;
    tile_d      = tile_q;
    beat_d      = beat_q;
    hold_d      = hold_q;
    err_cfg_d   = 1'b0;
    err_to_d    = err_to_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            len_d    = len_calc;
            w_d      = cfg_ofm_w;
            step_d   = {{(ADDR_W-10){1'b0}}, cfg_ofm_c[11:2]};
            tiles_d  = cfg_ofm_c[11:4];
            col_d    = 12'd0;
            row_d    = 12'd0;
            tile_d   = 8'd0;
            pix_d    = '0;
            err_to_d = 1'b0;
            state_d  = S_CLEAR;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        run_cnt_d = 20'd0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (last_run) begin
          drain_cnt_d = '0;
          state_d     = S_DRAIN;
        end else begin
          run_cnt_d = run_cnt_q + 20'd1;
        end
      end
      S_DRAIN: begin
        // Only a fully-valid cluster counts; partial valid keeps waiting.
        if (&valid_in) begin
          hold_d  = ofm_data_in;
          beat_d  = 2'd0;
          state_d = S_STORE;
        end else if (drain_cnt_q == DCW'(DRAIN_MAX - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        if (ofm_wr_ready) begin
          if (beat_q == 2'd3) state_d = S_NEXT;
          else                beat_d  = beat_q + 2'd1;
        end
      end
      S_NEXT: begin
        // pix_q tracks ((row*W+col)*OC)/4 incrementally so no multiplier is needed.
        state_d = S_CLEAR;
        if (col_q == w_q - 12'd1) begin
          col_d = 12'd0;
          if (row_q == w_q - 12'd1) begin
            row_d = 12'd0;
            pix_d = '0;
            if (tile_q == tiles_q - 8'd1) begin
              tile_d  = 8'd0;
              state_d = S_DONE;
            end else begin
              tile_d = tile_q + 8'd1;
            end
          end else begin
            row_d = row_q + 12'd1;
            pix_d = pix_q + step_q;
          end
        end else begin
          col_d = col_q + 12'd1;
          pix_d = pix_q + step_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      w_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      step_q      <= '0;
      pix_q       <= '0;
      tiles_q     <= '0;
      tile_q      <= '0;
      beat_q      <= '0;
      hold_q      <= '0;
      err_cfg_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      w_q         <= w_d;
      col_q       <= col_d;
      row_q       <= row_d;
      step_q      <= step_d;
      pix_q       <= pix_d;
      tiles_q     <= tiles_d;
      tile_q      <= tile_d;
      beat_q      <= beat_d;
      hold_q      <= hold_d;
      err_cfg_q   <= err_cfg_d;
      err_to_q    <= err_to_d;
    end
  end

  assign cal_start   = (state_q == S_RUN);
  assign PE_reset    = {NUM_PE{state_q == S_CLEAR}};
  assign PE_finish   = {NUM_PE{(state_q == S_RUN) && last_run}};
  assign ofm_wr_en   = (state_q == S_STORE);
  assign ofm_wr_addr = pix_q + {{(ADDR_W-10){1'b0}}, tile_q, 2'b00} + {{(ADDR_W-2){1'b0}}, beat_q};
  assign ofm_wr_data = hold_q[32*beat_q +: 32];
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler: config table jobs plus timeout and
// mid-run reset sequences, with a PE/OFM model and a write scoreboard.
module tb_conv_window_scheduler;
  localparam int DRAIN_MAX = 64;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   cfg_kernel_w;
  logic [11:0]  cfg_ifm_c, cfg_ofm_w, cfg_ofm_c;
  logic         cal_start;
  logic [15:0]  PE_reset, PE_finish, valid_in;
  logic [127:0] ofm_data_in;
  logic         ofm_wr_en, ofm_wr_ready;
  logic [31:0]  ofm_wr_addr, ofm_wr_data;
  logic         busy, done, err_cfg, err_timeout;

  always #5 clk = ~clk;

  conv_window_scheduler #(.NUM_PE(16), .ADDR_W(32), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_kernel_w(cfg_kernel_w), .cfg_ifm_c(cfg_ifm_c), .cfg_ofm_w(cfg_ofm_w), .cfg_ofm_c(cfg_ofm_c),
    .cal_start(cal_start), .PE_reset(PE_reset), .PE_finish(PE_finish),
    .valid_in(valid_in), .ofm_data_in(ofm_data_in),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data),
    .ofm_wr_ready(ofm_wr_ready), .busy(busy), .done(done),
    .err_cfg(err_cfg), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [3:0]  k;
    logic [11:0] ifm_c;
    logic [11:0] ofm_w;
    logic [11:0] ofm_c;
    int          ready_mode;  // 0: always ready, 1: ready one cycle in three
    bit          exp_err;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  int checks = 0, errors = 0;
  int cyc = 0;
  int cur_len, ready_mode = 0;
  bit pe_never = 0, lat_chk = 0, have_prev = 0, stalled = 0, to_seen = 0;
  int run_len = 0, preset_cnt = 0, cal_cnt = 0, done_cnt = 0, errcfg_cnt = 0;
  int prev_preset, fin_cyc, to_cyc, last_hs, done_cyc, wr_idx = 0, win_n = 0;
  logic [31:0] held_addr, held_data;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'((n * 17 + i * 5 + 3) & 255);
    return r;
  endfunction

  task automatic build_expected(input int w, input int oc);
    logic [127:0] p;
    int n;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int t = 0; t < oc / 16; t++)
      for (int r = 0; r < w; r++)
        for (int c = 0; c < w; c++) begin
          n = (t * w + r) * w + c;
          p = pat(n);
          for (int b = 0; b < 4; b++) begin
            exp_addr_q.push_back(32'(((r * w + c) * oc + t * 16) / 4 + b));
            exp_data_q.push_back(p[32*b +: 32]);
          end
        end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    ofm_wr_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  // PE cluster model: partial valid one cycle after finish, full valid the cycle after.
  initial begin
    valid_in = '0;
    ofm_data_in = '0;
    forever begin
      @(negedge clk);
      if (PE_finish == 16'hFFFF) begin
        ofm_data_in = pat(win_n);
        @(posedge clk); #1 valid_in = 16'h7FFF;
        @(posedge clk); #1 valid_in = pe_never ? 16'h7FFF : 16'hFFFF;
        @(posedge clk); #1 valid_in = 16'h0000;
        win_n++;
      end
    end
  end

  always @(negedge clk) begin
    if (cal_start) begin
      run_len++;
      cal_cnt++;
    end
    if (PE_finish == 16'hFFFF) begin
      check("win_len", 128'(run_len), 128'(cur_len));
      fin_cyc = cyc;
    end
    if (PE_reset == 16'hFFFF) begin
      run_len = 0;
      preset_cnt++;
      if (lat_chk && have_prev) check("win_latency", 128'(cyc - prev_preset), 128'(cur_len + 8));
      prev_preset = cyc;
      have_prev = 1;
    end
    if (ofm_wr_en) begin
      if (stalled) begin
        check("stall_addr", ofm_wr_addr, held_addr);
        check("stall_data", ofm_wr_data, held_data);
      end
      if (ofm_wr_ready) begin
        $display("wr %0d addr=%0d data=%08h", wr_idx, ofm_wr_addr, ofm_wr_data);
        if (wr_idx < exp_addr_q.size()) begin
          check("wr_addr", ofm_wr_addr, exp_addr_q[wr_idx]);
          check("wr_data", ofm_wr_data, exp_data_q[wr_idx]);
        end else begin
          check("write_overflow", 128'(wr_idx), 128'(exp_addr_q.size() - 1));
        end
        wr_idx++;
        last_hs = cyc;
        stalled = 0;
      end else begin
        stalled = 1;
        held_addr = ofm_wr_addr;
        held_data = ofm_wr_data;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_cfg) errcfg_cnt++;
    if (err_timeout && !to_seen) begin
      to_seen = 1;
      to_cyc = cyc;
    end
  end

  task automatic clear_counters();
    wr_idx = 0; done_cnt = 0; preset_cnt = 0; cal_cnt = 0; errcfg_cnt = 0;
    stalled = 0; have_prev = 0; win_n = 0; to_seen = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_job(input int idx);
    vec_t v;
    int t, windows;
    v = vecs[idx];
    cur_len = v.exp_len;
    ready_mode = v.ready_mode;
    lat_chk = (v.ready_mode == 0);
    if (v.exp_err) begin
      exp_addr_q.delete();
      exp_data_q.delete();
    end else begin
      build_expected(int'(v.ofm_w), int'(v.ofm_c));
    end
    clear_counters();
    cfg_kernel_w = v.k; cfg_ifm_c = v.ifm_c; cfg_ofm_w = v.ofm_w; cfg_ofm_c = v.ofm_c;
    pulse_start();
    if (v.exp_err) begin
      repeat (5) @(posedge clk);
      #1;
      check($sformatf("v%0d_err_cfg_pulses", idx), 128'(errcfg_cnt), 128'(1));
      check($sformatf("v%0d_no_pe_reset", idx), 128'(preset_cnt), 128'(0));
      check($sformatf("v%0d_no_cal_start", idx), 128'(cal_cnt), 128'(0));
      check($sformatf("v%0d_idle", idx), 128'(busy), 128'(0));
    end else begin
      check($sformatf("v%0d_busy_after_start", idx), 128'(busy), 128'(1));
      check($sformatf("v%0d_err_timeout_clear", idx), 128'(err_timeout), 128'(0));
      // a start with different config while busy must be ignored
      repeat (30) @(posedge clk);
      #1 cfg_ofm_w = 12'd5; cfg_kernel_w = 4'd7;
      pulse_start();
      t = 0;
      while (done_cnt == 0 && t < 20000) begin
        @(posedge clk);
        t++;
      end
      repeat (2) @(posedge clk);
      #1;
      windows = int'(v.ofm_w) * int'(v.ofm_w) * (int'(v.ofm_c) / 16);
      check($sformatf("v%0d_writes", idx), 128'(wr_idx), 128'(exp_addr_q.size()));
      check($sformatf("v%0d_done_pulses", idx), 128'(done_cnt), 128'(1));
      check($sformatf("v%0d_done_gap", idx), 128'(done_cyc - last_hs), 128'(2));
      check($sformatf("v%0d_windows", idx), 128'(preset_cnt), 128'(windows));
      check($sformatf("v%0d_busy_end", idx), 128'(busy), 128'(0));
      check($sformatf("v%0d_err_cfg", idx), 128'(errcfg_cnt), 128'(0));
      check($sformatf("v%0d_err_timeout", idx), 128'(err_timeout), 128'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; start = 1'b0;
    cfg_kernel_w = '0; cfg_ifm_c = '0; cfg_ofm_w = '0; cfg_ofm_c = '0;
    vecs[0] = '{4'd3, 12'd32, 12'd2, 12'd16, 0, 1'b0, 72};
    vecs[1] = '{4'd3, 12'd32, 12'd2, 12'd32, 0, 1'b0, 72};
    vecs[2] = '{4'd3, 12'd32, 12'd2, 12'd16, 1, 1'b0, 72};
    vecs[3] = '{4'd3, 12'd30, 12'd2, 12'd16, 0, 1'b1, 0};
    vecs[4] = '{4'd3, 12'd32, 12'd2, 12'd20, 0, 1'b1, 0};
    vecs[5] = '{4'd1, 12'd4,  12'd3, 12'd16, 0, 1'b0, 1};
    vecs[6] = '{4'd0, 12'd32, 12'd2, 12'd16, 0, 1'b1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {cal_start, PE_reset, PE_finish, ofm_wr_en, done, err_cfg, err_timeout, busy}, '0);
    check("rst_addr", ofm_wr_addr, 32'd0);
    check("rst_data", ofm_wr_data, 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 7; i++) run_job(i);

    // DRAIN timeout: full valid never arrives
    pe_never = 1; cur_len = 1; lat_chk = 0; ready_mode = 0;
    exp_addr_q.delete(); exp_data_q.delete();
    clear_counters();
    cfg_kernel_w = 4'd1; cfg_ifm_c = 12'd4; cfg_ofm_w = 12'd1; cfg_ofm_c = 12'd16;
    pulse_start();
    t = 0;
    while (!to_seen && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("to_flag", 128'(err_timeout), 128'(1));
    check("to_delay", 128'(to_cyc - fin_cyc), 128'(DRAIN_MAX + 1));
    check("to_idle", 128'(busy), 128'(0));
    check("to_no_done", 128'(done_cnt), 128'(0));
    check("to_no_writes", 128'(wr_idx), 128'(0));
    pe_never = 0;
    run_job(0);

    // asynchronous reset in the middle of RUN
    cur_len = 72; lat_chk = 0;
    clear_counters();
    cfg_kernel_w = 4'd3; cfg_ifm_c = 12'd32; cfg_ofm_w = 12'd2; cfg_ofm_c = 12'd16;
    pulse_start();
    t = 0;
    while (!cal_start && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_run_reached", 128'(cal_start), 128'(1));
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ctrl", {cal_start, PE_reset, PE_finish, ofm_wr_en, done, err_cfg, err_timeout, busy}, '0);
    check("async_rst_addr", ofm_wr_addr, 32'd0);
    @(negedge clk) reset = 1'b0;
    run_job(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
